enemy_shot_unit: RTL

Receives the one-hot enemy fire selection produced by the game engine and turns it into live enemy projectiles. Keeps a small pool of shot slots, spawns each shot under the selected enemy in the formation, and moves it down the screen on every movement step. Retires shots that leave the playfield or strike the player, and pulses `player_hit` toward the player-life logic.

---
 rtl/enemy_shot_unit_if.sv | 40 ++++
 rtl/enemy_shot_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/enemy_shot_unit_if.sv
// enemy_shot_unit_if
// Bundles the engine-facing signals of enemy_shot_unit.
//   master : game engine side. It drives restart, fire, formation and player
//            inputs, and it receives the shot pool state and the pulses.
//   slave  : enemy_shot_unit side.
// Parameters N_ENEMIES and MAX_SHOTS must match those of the attached unit.
interface enemy_shot_unit_if #(
   parameter int N_ENEMIES = 6,
   parameter int MAX_SHOTS = 4
);
   localparam int CNT_W = $clog2(MAX_SHOTS + 1);

   logic                   restart;
   logic                   fire_valid;
   logic [N_ENEMIES-1:0]   ID_enemy_tiro;
   logic [N_ENEMIES-1:0]   enemy_vivos;
   logic [7:0]             bloco_pos_X;
   logic [7:0]             bloco_pos_Y;
   logic [7:0]             player_x;
   logic                   step;

   logic [MAX_SHOTS-1:0]   shot_valid;
   logic [8*MAX_SHOTS-1:0] shot_x;
   logic [8*MAX_SHOTS-1:0] shot_y;
   logic [CNT_W-1:0]       shot_count;
   logic                   player_hit;
   logic                   fire_drop;

   modport master (
      output restart, fire_valid, ID_enemy_tiro, enemy_vivos,
             bloco_pos_X, bloco_pos_Y, player_x, step,
      input  shot_valid, shot_x, shot_y, shot_count, player_hit, fire_drop
   );

   modport slave (
      input  restart, fire_valid, ID_enemy_tiro, enemy_vivos,
             bloco_pos_X, bloco_pos_Y, player_x, step,
      output shot_valid, shot_x, shot_y, shot_count, player_hit, fire_drop
   );
endinterface

// File: rtl/enemy_shot_unit.sv
// enemy_shot_unit
// Turns one-hot enemy fire requests into projectiles held in a small pool of
// slots. Each step moves the shots down the screen. A shot is retired when it
// leaves the playfield or strikes the player. A strike pulses player_hit.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : enemy_shot_unit_if.slave. It carries restart, the fire request,
//           the formation origin, player_x and step. It returns the slot
//           occupancy, the packed coordinates, the shot count, player_hit and
//           fire_drop.
// Optional feature: define ENEMY_SHOT_FLUSH_ON_HIT_EN to clear the whole pool
// whenever the player is hit.
module enemy_shot_unit #(
   parameter int N_ENEMIES     = 6,
   parameter int MAX_SHOTS     = 4,
   parameter int ENEMY_SPACING = 16,
   parameter int ENEMY_H       = 8,
   parameter int SHOT_SPEED    = 2,
   parameter int SCREEN_H      = 240,
   parameter int PLAYER_Y      = 224,
   parameter int PLAYER_W      = 16,
   parameter int PLAYER_H      = 8
) (
   input logic              clk,
   input logic              reset,
   enemy_shot_unit_if.slave bus
);
   localparam int SLOT_W = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1;
   localparam int CNT_W  = $clog2(MAX_SHOTS + 1);
   localparam logic [N_ENEMIES-1:0] ID_ONE = 1;

   logic [MAX_SHOTS-1:0] valid_q, valid_d;
   logic [7:0]           x_q [MAX_SHOTS];
   logic [7:0]           x_d [MAX_SHOTS];
   logic [7:0]           y_q [MAX_SHOTS];
   logic [7:0]           y_d [MAX_SHOTS];
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 hit_q, hit_d;
   logic                 drop_q, drop_d;

   logic [N_ENEMIES-1:0] id;
   logic                 fire_ok;
   logic                 spawn_ok;
   logic [8:0]           spawn_x9;
   logic [8:0]           spawn_y9;
   logic [7:0]           spawn_x;
   logic                 free_found;
   logic [SLOT_W-1:0]    free_idx;
   logic [8:0]           px_hi9;

   // Decode the request, compute the spawn point and find a free slot.
   always_comb begin
      id = bus.ID_enemy_tiro;
      // A value is one-hot when it is nonzero and clearing its lowest set bit leaves zero.
      fire_ok = bus.fire_valid && (id != '0) && ((id & (id - ID_ONE)) == '0)
                && ((id & bus.enemy_vivos) != '0);

      spawn_x9 = '0;
      for (int j = 0; j < N_ENEMIES; j++) begin
         if (id[j]) begin
            spawn_x9 = {1'b0, bus.bloco_pos_X} + 9'(j * ENEMY_SPACING + ENEMY_SPACING / 2);
         end
      end
      spawn_x  = spawn_x9[8] ? 8'hFF : spawn_x9[7:0];
      spawn_y9 = {1'b0, bus.bloco_pos_Y} + 9'(ENEMY_H);
      // A shot that would spawn off-screen is still an accepted request, so no drop pulse is raised.
      spawn_ok = fire_ok && (spawn_y9 < 9'(SCREEN_H));

      // Free-slot search uses the occupancy before this cycle's step, so a slot the step frees is not reused this cycle.
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = MAX_SHOTS - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = SLOT_W'(i);
         end
      end

      px_hi9 = {1'b0, bus.player_x} + 9'(PLAYER_W);
   end

   // Next state: move existing shots, then place the new shot, then apply flush and restart.
   always_comb begin
      logic [8:0] y_nxt;
      valid_d = valid_q;
      x_d     = x_q;
      y_d     = y_q;
      hit_d   = 1'b0;
      drop_d  = 1'b0;
      y_nxt   = '0;

      if (bus.step) begin
         for (int i = 0; i < MAX_SHOTS; i++) begin
            if (valid_q[i]) begin
               y_nxt = {1'b0, y_q[i]} + 9'(SHOT_SPEED);
               if (y_nxt >= 9'(SCREEN_H)) begin
                  valid_d[i] = 1'b0;
                  x_d[i]     = '0;
                  y_d[i]     = '0;
               end else if ((y_nxt >= 9'(PLAYER_Y)) && (y_nxt < 9'(PLAYER_Y + PLAYER_H))
                            && ({1'b0, x_q[i]} >= {1'b0, bus.player_x})
                            && ({1'b0, x_q[i]} < px_hi9)) begin
                  valid_d[i] = 1'b0;
                  x_d[i]     = '0;
                  y_d[i]     = '0;
                  hit_d      = 1'b1;
               end else begin
                  y_d[i] = y_nxt[7:0];
               end
            end
         end
      end

      if (spawn_ok) begin
         if (free_found) begin
            valid_d[free_idx] = 1'b1;
            x_d[free_idx]     = spawn_x;
            y_d[free_idx]     = spawn_y9[7:0];
         end else begin
            drop_d = 1'b1;
         end
      end

`ifdef ENEMY_SHOT_FLUSH_ON_HIT_EN
      if (hit_d) begin
         valid_d = '0;
         for (int i = 0; i < MAX_SHOTS; i++) begin
            x_d[i] = '0;
            y_d[i] = '0;
         end
      end
`else
      // Only the hitting slots are freed. The other shots keep moving.
`endif

      if (bus.restart) begin
         valid_d = '0;
         hit_d   = 1'b0;
         drop_d  = 1'b0;
         for (int i = 0; i < MAX_SHOTS; i++) begin
            x_d[i] = '0;
            y_d[i] = '0;
         end
      end

      count_d = '0;
      for (int i = 0; i < MAX_SHOTS; i++) begin
         count_d = count_d + CNT_W'(valid_d[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         x_q     <= '{default: '0};
         y_q     <= '{default: '0};
         count_q <= '0;
         hit_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         x_q     <= x_d;
         y_q     <= y_d;
         count_q <= count_d;
         hit_q   <= hit_d;
         drop_q  <= drop_d;
      end
   end

   for (genvar g = 0; g < MAX_SHOTS; g++) begin : g_pack
      assign bus.shot_x[8*g +: 8] = x_q[g];
      assign bus.shot_y[8*g +: 8] = y_q[g];
   end

   assign bus.shot_valid = valid_q;
   assign bus.shot_count = count_q;
   assign bus.player_hit = hit_q;
   assign bus.fire_drop  = drop_q;
endmodule
